// File: rtl/sha256_k_scan.sv
// SHA-256 round-constant scanner: walks Kt through a registered ROM and shows one byte on LEDs.
// Optional define SHA256_K_SCAN_CHECKSUM_EN adds a per-sweep XOR checksum output port.

module SHA256_K_mem (
  input  logic        hwclk,
  input  logic [5:0]  addr,
  output logic [31:0] k
);

  // FIPS 180-4 round constants, one-cycle registered read.
  always_ff @(posedge hwclk) begin
    case (addr)
      6'd0:  k <= 32'h428a2f98;
      6'd1:  k <= 32'h71374491;
      6'd2:  k <= 32'hb5c0fbcf;
      6'd3:  k <= 32'he9b5dba5;
      6'd4:  k <= 32'h3956c25b;
      6'd5:  k <= 32'h59f111f1;
      6'd6:  k <= 32'h923f82a4;
      6'd7:  k <= 32'hab1c5ed5;
      6'd8:  k <= 32'hd807aa98;
      6'd9:  k <= 32'h12835b01;
      6'd10: k <= 32'h243185be;
      6'd11: k <= 32'h550c7dc3;
      6'd12: k <= 32'h72be5d74;
      6'd13: k <= 32'h80deb1fe;
      6'd14: k <= 32'h9bdc06a7;
      6'd15: k <= 32'hc19bf174;
      6'd16: k <= 32'he49b69c1;
      6'd17: k <= 32'hefbe4786;
      6'd18: k <= 32'h0fc19dc6;
      6'd19: k <= 32'h240ca1cc;
      6'd20: k <= 32'h2de92c6f;
      6'd21: k <= 32'h4a7484aa;
      6'd22: k <= 32'h5cb0a9dc;
      6'd23: k <= 32'h76f988da;
      6'd24: k <= 32'h983e5152;
      6'd25: k <= 32'ha831c66d;
      6'd26: k <= 32'hb00327c8;
      6'd27: k <= 32'hbf597fc7;
      6'd28: k <= 32'hc6e00bf3;
      6'd29: k <= 32'hd5a79147;
      6'd30: k <= 32'h06ca6351;
      6'd31: k <= 32'h14292967;
      6'd32: k <= 32'h27b70a85;
      6'd33: k <= 32'h2e1b2138;
      6'd34: k <= 32'h4d2c6dfc;
      6'd35: k <= 32'h53380d13;
      6'd36: k <= 32'h650a7354;
      6'd37: k <= 32'h766a0abb;
      6'd38: k <= 32'h81c2c92e;
      6'd39: k <= 32'h92722c85;
      6'd40: k <= 32'ha2bfe8a1;
      6'd41: k <= 32'ha81a664b;
      6'd42: k <= 32'hc24b8b70;
      6'd43: k <= 32'hc76c51a3;
      6'd44: k <= 32'hd192e819;
      6'd45: k <= 32'hd6990624;
      6'd46: k <= 32'hf40e3585;
      6'd47: k <= 32'h106aa070;
      6'd48: k <= 32'h19a4c116;
      6'd49: k <= 32'h1e376c08;
      6'd50: k <= 32'h2748774c;
      6'd51: k <= 32'h34b0bcb5;
      6'd52: k <= 32'h391c0cb3;
      6'd53: k <= 32'h4ed8aa4a;
      6'd54: k <= 32'h5b9cca4f;
      6'd55: k <= 32'h682e6ff3;
      6'd56: k <= 32'h748f82ee;
      6'd57: k <= 32'h78a5636f;
      6'd58: k <= 32'h84c87814;
      6'd59: k <= 32'h8cc70208;
      6'd60: k <= 32'h90befffa;
      6'd61: k <= 32'ha4506ceb;
      6'd62: k <= 32'hbef9a3f7;
      default: k <= 32'hc67178f2;
    endcase
  end

endmodule

module sha256_k_scan #(
  parameter int CLK_DIV_WIDTH = 16,
  parameter bit LED_INVERT    = 1'b0
) (
  input  logic        hwclk,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic        step,
  input  logic [1:0]  lane_sel,
  output logic [7:0]  LEDs,
  output logic [5:0]  round_out,
  output logic        sweep_done
`ifdef SHA256_K_SCAN_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  typedef enum logic [2:0] {IDLE, RUN, STEP, SWEEP, DONE} state_t;

  localparam logic [CLK_DIV_WIDTH-1:0] DIV_ONE   = CLK_DIV_WIDTH'(1);
  localparam logic [7:0]               LED_RESET = LED_INVERT ? 8'hFF : 8'h00;

  state_t                     state, state_nxt;
  logic [CLK_DIV_WIDTH-1:0]   div_cnt;
  logic                       tick;
  logic                       step_q, step_rise;
  logic [5:0]                 round, round_nxt, round_d;
  logic                       sweep_start;
  logic [31:0]                k_word;
  logic                       k_valid;
  logic [7:0]                 lane_byte;

  function automatic state_t mode_state(input logic [1:0] m);
    case (m)
      2'b01:   return RUN;
      2'b10:   return STEP;
      2'b11:   return SWEEP;
      default: return IDLE;
    endcase
  endfunction

  assign tick      = &div_cnt;
  assign step_rise = step & ~step_q;

  always_ff @(posedge hwclk) begin
    if (reset) begin
      div_cnt <= '0;
      step_q  <= 1'b0;
      state   <= IDLE;
      round   <= 6'd0;
    end else begin
      div_cnt <= div_cnt + DIV_ONE;
      step_q  <= step;
      state   <= state_nxt;
      round   <= round_nxt;
    end
  end

  // SWEEP and DONE only leave when mode stops being 11; the other states follow mode directly.
  always_comb begin
    state_nxt = state;
    case (state)
      SWEEP: begin
        if (mode != 2'b11)
          state_nxt = mode_state(mode);
        else if (tick && round == 6'd63)
          state_nxt = DONE;
      end
      DONE: begin
        if (mode != 2'b11)
          state_nxt = mode_state(mode);
      end
      default: state_nxt = mode_state(mode);
    endcase
  end

  // The state being entered picks the single event (tick or step edge) that may advance the round.
  always_comb begin
    sweep_start = (state != SWEEP) && (state != DONE) && (state_nxt == SWEEP);
    round_nxt   = round;
    sweep_done  = (state == DONE);
    case (state_nxt)
      RUN:   if (tick)        round_nxt = round + 6'd1;
      STEP:  if (step_rise)   round_nxt = round + 6'd1;
      SWEEP: begin
        if (sweep_start)      round_nxt = 6'd0;
        else if (tick)        round_nxt = round + 6'd1;
      end
      default: ;
    endcase
  end

  SHA256_K_mem u_k_mem (
    .hwclk (hwclk),
    .addr  (round),
    .k     (k_word)
  );

  always_comb begin
    case (lane_sel)
      2'd0:    lane_byte = k_word[7:0];
      2'd1:    lane_byte = k_word[15:8];
      2'd2:    lane_byte = k_word[23:16];
      default: lane_byte = k_word[31:24];
    endcase
  end

  // k_valid keeps the reset pattern on the LEDs until the ROM has produced a word for round 0.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      round_d   <= 6'd0;
      k_valid   <= 1'b0;
      LEDs      <= LED_RESET;
      round_out <= 6'd0;
    end else begin
      round_d <= round;
      k_valid <= 1'b1;
      if (k_valid) begin
        LEDs      <= lane_byte ^ {8{LED_INVERT}};
        round_out <= round_d;
      end
    end
  end

`ifdef SHA256_K_SCAN_CHECKSUM_EN
  logic       sweep_adv;
  logic [1:0] csum_pipe;

  assign sweep_adv = (state == SWEEP) && (state_nxt == SWEEP) && tick;

  // A newly entered sweep round has its Kt in k_word two edges later; fold it in then.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      csum_pipe <= 2'b00;
      checksum  <= 32'd0;
    end else begin
      csum_pipe <= {csum_pipe[0], sweep_start | sweep_adv};
      if (sweep_start)
        checksum <= 32'd0;
      else if (csum_pipe[1] && state == SWEEP)
        checksum <= checksum ^ k_word;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_k_scan.sv
// Scoreboard bench for sha256_k_scan: a cycle model predicts outputs, a monitor compares them.
// Two DUT copies share stimulus, one with inverted LEDs.

module tb_sha256_k_scan;

  localparam int W = 2;

  logic       hwclk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       step = 1'b0;
  logic [1:0] lane_sel = 2'd3;

  logic [7:0] leds, leds_inv;
  logic [5:0] round_out, round_out_inv;
  logic       sweep_done, sweep_done_inv;
`ifdef SHA256_K_SCAN_CHECKSUM_EN
  logic [31:0] checksum, checksum_inv;
`endif

  always #5 hwclk = ~hwclk;

  sha256_k_scan #(.CLK_DIV_WIDTH(W), .LED_INVERT(1'b0)) dut (
    .hwclk      (hwclk),
    .reset      (reset),
    .mode       (mode),
    .step       (step),
    .lane_sel   (lane_sel),
    .LEDs       (leds),
    .round_out  (round_out),
`ifdef SHA256_K_SCAN_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .sweep_done (sweep_done)
  );

  sha256_k_scan #(.CLK_DIV_WIDTH(W), .LED_INVERT(1'b1)) dut_inv (
    .hwclk      (hwclk),
    .reset      (reset),
    .mode       (mode),
    .step       (step),
    .lane_sel   (lane_sel),
    .LEDs       (leds_inv),
    .round_out  (round_out_inv),
`ifdef SHA256_K_SCAN_CHECKSUM_EN
    .checksum   (checksum_inv),
`endif
    .sweep_done (sweep_done_inv)
  );

  logic [31:0] k_ref [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct packed {
    logic [7:0]  leds;
    logic [5:0]  rnd;
    logic        done;
    logic        csum_chk;
    logic [31:0] csum;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_push  = 0;
  int   n_pop   = 0;
  int   cyc     = 0;

  // Reference model: the round as the spec's mode rules describe it, plus a history of rounds.
  int          m_cnt, m_round, m_since;
  bit          m_sweeping, m_done, m_step_prev;
  int          m_rh [3];
  logic [31:0] k_xor_all;

  task automatic model_edge(input logic r, input logic [1:0] m, input logic s, input logic [1:0] l);
    exp_t e;
    bit   tk, rise;
    if (r) begin
      m_cnt = 0; m_round = 0; m_step_prev = 0; m_sweeping = 0; m_done = 0; m_since = 0;
      m_rh = '{0, 0, 0};
    end else begin
      tk   = (m_cnt == (1 << W) - 1);
      rise = s && !m_step_prev;
      if (m == 2'b11) begin
        if (!m_sweeping && !m_done) begin
          m_sweeping = 1; m_round = 0;
        end else if (m_sweeping && tk) begin
          if (m_round == 63) begin m_sweeping = 0; m_done = 1; end
          else m_round = m_round + 1;
        end
      end else begin
        m_sweeping = 0; m_done = 0;
        if (m == 2'b01 && tk)   m_round = (m_round + 1) % 64;
        if (m == 2'b10 && rise) m_round = (m_round + 1) % 64;
      end
      m_cnt = (m_cnt + 1) % (1 << W);
      m_step_prev = s;
      if (m_since < 2) m_since = m_since + 1;
      m_rh[2] = m_rh[1]; m_rh[1] = m_rh[0]; m_rh[0] = m_round;
    end
    e.rnd      = 6'(m_rh[2]);
    e.leds     = (m_since < 2) ? 8'h00 : 8'(k_ref[m_rh[2]] >> (8 * l));
    e.done     = m_done;
    e.csum_chk = m_done;
    e.csum     = k_xor_all;
    sb_q.push_back(e);
    n_push++;
  endtask

  task automatic apply_stimulus(input logic r, input logic [1:0] m, input logic s,
                                input logic [1:0] l, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge hwclk);
      reset = r; mode = m; step = s; lane_sel = l;
      @(posedge hwclk);
      model_edge(r, m, s, l);
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      if (n_fail <= 30)
        $display("[TB] FAIL %s cycle=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  // Monitor: every cycle the DUTs present outputs; pop the prediction and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge hwclk);
      #1;
      cyc++;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_pop++;
        check_output("leds", {24'd0, leds}, {24'd0, e.leds});
        check_output("leds_inv", {24'd0, leds_inv}, {24'd0, ~e.leds});
        check_output("round_out", {26'd0, round_out}, {26'd0, e.rnd});
        check_output("round_out_inv", {26'd0, round_out_inv}, {26'd0, e.rnd});
        check_output("sweep_done", {31'd0, sweep_done}, {31'd0, e.done});
        check_output("sweep_done_inv", {31'd0, sweep_done_inv}, {31'd0, e.done});
`ifdef SHA256_K_SCAN_CHECKSUM_EN
        if (e.csum_chk) check_output("checksum", checksum, e.csum);
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    n_tests++; n_fail++;
    $display("[TB] FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    logic [1:0] rm, rl;
    logic       rs;
    int         len;
    k_xor_all = 32'd0;
    for (int i = 0; i < 64; i++) k_xor_all ^= k_ref[i];

    $display("[TB] reset then HOLD, lane 3");
    apply_stimulus(1'b1, 2'b00, 1'b0, 2'd3, 4);
    apply_stimulus(1'b0, 2'b00, 1'b0, 2'd3, 100);

    $display("[TB] RUN lane 0 through a full wrap");
    apply_stimulus(1'b0, 2'b01, 1'b0, 2'd0, 64 * 4 + 10);

    $display("[TB] STEP with step held high");
    apply_stimulus(1'b0, 2'b10, 1'b1, 2'd0, 20);
    apply_stimulus(1'b0, 2'b10, 1'b0, 2'd1, 12);

    $display("[TB] SWEEP lane 3 to completion");
    apply_stimulus(1'b0, 2'b11, 1'b0, 2'd3, 64 * 4 + 20);
    apply_stimulus(1'b0, 2'b00, 1'b0, 2'd3, 3);

    $display("[TB] SWEEP interrupted by reset near round 30");
    apply_stimulus(1'b0, 2'b11, 1'b0, 2'd3, 30 * 4 + 2);
    apply_stimulus(1'b1, 2'b11, 1'b0, 2'd3, 3);
    apply_stimulus(1'b0, 2'b11, 1'b0, 2'd3, 64 * 4 + 12);

    $display("[TB] SWEEP aborted by mode change");
    apply_stimulus(1'b0, 2'b00, 1'b0, 2'd2, 2);
    apply_stimulus(1'b0, 2'b11, 1'b0, 2'd2, 40);
    apply_stimulus(1'b0, 2'b01, 1'b0, 2'd2, 10);

    $display("[TB] randomized segments");
    for (int seg = 0; seg < 80; seg++) begin
      rm  = 2'($urandom_range(0, 3));
      len = (rm == 2'b11 && $urandom_range(0, 2) == 0) ? 270 : $urandom_range(1, 40);
      if ($urandom_range(0, 24) == 0)
        apply_stimulus(1'b1, rm, 1'b0, 2'd0, $urandom_range(1, 3));
      for (int c = 0; c < len; c++) begin
        rs = ($urandom_range(0, 3) == 0);
        rl = 2'($urandom_range(0, 3));
        apply_stimulus(1'b0, rm, rs, rl, 1);
      end
    end

    repeat (3) @(posedge hwclk);
    #2;
    check_output("drain", n_pop, n_push);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_k_scan.md
SHA256_K_SCAN -- requirements
Module: sha256_k_scan

Interface
REQ-001 Parameter CLK_DIV_WIDTH, default 16, tick divider width; legal range 2..24.
REQ-002 Parameter LED_INVERT, default 0; 1 = LEDs driven active-low (bitwise inverted).
REQ-003 hwclk  input  1  sole clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mode  input  2  00 HOLD, 01 RUN, 10 STEP, 11 SWEEP.
REQ-006 step  input  1  synchronous level from board/bench; rising edge advances round in STEP mode.
REQ-007 lane_sel  input  2  byte lane of Kt shown on LEDs (0 = Kt[7:0] ... 3 = Kt[31:24]).
REQ-008 LEDs  output  8  selected Kt byte, registered.
REQ-009 round_out  output  6  round index of the Kt currently on LEDs.
REQ-010 sweep_done  output  1  high while in DONE after a completed SWEEP.

Function
REQ-011 Divider SHALL be a free-running CLK_DIV_WIDTH-bit counter; tick SHALL pulse exactly one hwclk cycle when counter is all-ones, then counter wraps to 0; no derived/gated clocks.
REQ-012 K constants SHALL come from an instantiated SHA256_K_mem clocked by hwclk, address = internal round register; read latency one hwclk cycle.
REQ-013 LEDs/round_out SHALL update one cycle after the Kt read completes (2 cycles after round changes); lane_sel change SHALL reach LEDs in 1 cycle.
REQ-014 FSM states IDLE, RUN, STEP, SWEEP, DONE; state decoded from mode each cycle except SWEEP/DONE as below.
REQ-015 IDLE (mode 00): round frozen.
REQ-016 RUN (mode 01): round increments by 1 on each tick, wraps 63 -> 0.
REQ-017 STEP (mode 10): round increments once per step rising edge (step registered; edge = step & ~step_q); tick ignored; held step SHALL advance only once.
REQ-018 Entering SWEEP (mode changes to 11 from any other mode) SHALL load round = 0, then increment on tick; after round 63 has been presented, transition to DONE, round held at 63.
REQ-019 DONE: sweep_done = 1; remains until mode leaves 11, then goes to the mode's state with round unchanged; re-entering 11 restarts sweep from 0.
REQ-020 Mode change mid-SWEEP SHALL abort sweep, keep current round, sweep_done stays 0.
REQ-021 Tick and step edge in same cycle: only the event belonging to the current mode acts; never double increment.
REQ-022 Round arithmetic 6-bit unsigned modulo 64.

Reset
REQ-023 On reset: divider = 0, round = 0, step_q = 0, state = IDLE, sweep_done = 0, round_out = 0, LEDs = 8'h00 (8'hFF when LED_INVERT = 1).
REQ-024 Reset SHALL override all inputs in the same cycle; reset mid-sweep abandons sweep; after release a held mode 11 starts a fresh sweep.
REQ-025 First valid Kt on LEDs SHALL appear no later than 2 cycles after reset deasserts.

Configuration
REQ-026 Macro SHA256_K_SCAN_CHECKSUM_EN: when defined, adds output checksum (32 bits), XOR of every Kt presented during the current SWEEP, cleared on sweep start and reset, frozen in DONE and on abort.
REQ-027 When undefined, no checksum port or accumulator exists; all other behaviour identical.

Verification (CLK_DIV_WIDTH = 2, tick every 4 cycles)
REQ-028 Reset, mode 00, lane 3 -> LEDs = 8'h42, round_out = 0 held for 100 cycles.
REQ-029 Mode 01, lane 0 -> LEDs 8'h98, 8'h91 (K1 = 71374491) at successive ticks; after 64 ticks round_out wraps to 0.
REQ-030 Mode 10, step held high 20 cycles then low -> round_out advances exactly 1; ticks cause no change.
REQ-031 Mode 11, lane 3 -> sweep_done rises after round 63 presented, LEDs = 8'hC6 (K63 = C67178F2); with macro, checksum equals bench XOR of all 64 FIPS 180-4 K constants.
REQ-032 Reset asserted at round 30 of SWEEP, mode kept 11 -> outputs at reset values, then fresh sweep from round 0, sweep_done = 0 until completion.
REQ-033 LED_INVERT = 1, reset, lane 3 -> LEDs = 8'hFF during reset, 8'hBD after.
